// File: rtl/ttt_pkg.sv
// ttt_pkg: shared constants for the tic-tac-toe move-entry front end
package ttt_pkg;
    localparam int GRID_SQUARES   = 9;
    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 50000;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_REL = 1'b1;
    function automatic logic multi_set(input logic [GRID_SQUARES-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < GRID_SQUARES; i++) n += int'(v[i]);
        return n >= 2;
    endfunction
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchroniser plus shared-counter debouncer for a WIDTH-bit vector
module debounce #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level
);
    logic [WIDTH-1:0] s1, s2, s2_d;
    logic [CNT_W-1:0] cnt;
    logic differ, changed, done;
    assign differ  = s2 != level;
    assign changed = s2 != s2_d;
    assign done    = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    // any movement of the synced vector restarts the count, so level only loads a settled vector
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1    <= '0;
            s2    <= '0;
            s2_d  <= '0;
            cnt   <= '0;
            level <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            s2_d <= s2;
            if (!differ || changed) cnt <= '0;
            else if (done) begin
                cnt   <= '0;
                level <= s2;
            end else cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/move_entry.sv
// move_entry: conditions board switches and player buttons into single-cycle move strobes
module move_entry
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [GRID_SQUARES-1:0] raw_sel,
    input  logic                    raw_buttonX,
    input  logic                    raw_buttonO,
    output logic [GRID_SQUARES-1:0] sel_pos,
    output logic                    buttonX,
    output logic                    buttonO,
    output logic                    multi_sel,
    output logic                    busy
);
    logic db_x, db_o, db_x_d1, db_o_d1, rise_x, rise_o;
    logic [GRID_SQUARES-1:0] db_sel;
    logic [0:0] state;
    debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_x (
        .clk(clk), .reset(reset), .raw(raw_buttonX), .level(db_x)
    );
    debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_o (
        .clk(clk), .reset(reset), .raw(raw_buttonO), .level(db_o)
    );
    debounce #(.WIDTH(GRID_SQUARES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_sel (
        .clk(clk), .reset(reset), .raw(raw_sel), .level(db_sel)
    );
    assign rise_x = db_x & ~db_x_d1;
    assign rise_o = db_o & ~db_o_d1;
    assign busy   = state == ST_WAIT_REL;
    // rises while waiting for release are swallowed: the d1 flops keep tracking regardless of state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            db_x_d1   <= 1'b0;
            db_o_d1   <= 1'b0;
            state     <= ST_IDLE;
            buttonX   <= 1'b0;
            buttonO   <= 1'b0;
            sel_pos   <= '0;
            multi_sel <= 1'b0;
        end else begin
            db_x_d1   <= db_x;
            db_o_d1   <= db_o;
            multi_sel <= multi_set(db_sel);
            buttonX   <= state == ST_IDLE && rise_x;
            buttonO   <= state == ST_IDLE && rise_o;
            if (state == ST_IDLE && (rise_x || rise_o)) begin
                state   <= ST_WAIT_REL;
                sel_pos <= db_sel;
            end else if (state == ST_WAIT_REL && !db_x && !db_o) state <= ST_IDLE;
        end
endmodule

// File: tb/tb_move_entry.sv
// tb_move_entry: directed and random checks of move_entry against a window-based reference model
module tb_move_entry;
    localparam int D = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [8:0] raw_sel = '0;
    logic raw_buttonX = 1'b0, raw_buttonO = 1'b0;
    logic [8:0] sel_pos;
    logic buttonX, buttonO, multi_sel, busy;
    int n_cmp = 0, n_bad = 0;
    logic [10:0] h[$];
    logic m_x, m_o, m_x_d1, m_o_d1, m_bx, m_bo, m_busy, m_multi;
    logic [8:0] m_sel, m_selpos;
    int stp, nx, no_, fx, fo, busy_hi;
    logic [8:0] sx_pos;

    move_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .raw_sel(raw_sel), .raw_buttonX(raw_buttonX),
        .raw_buttonO(raw_buttonO), .sel_pos(sel_pos), .buttonX(buttonX),
        .buttonO(buttonO), .multi_sel(multi_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h.delete();
        for (int k = 0; k < D + 3; k++) h.push_back('0);
        {m_x, m_o, m_x_d1, m_o_d1, m_bx, m_bo, m_busy, m_multi} = '0;
        m_sel = '0;
        m_selpos = '0;
    endtask

    // a debounced value adopts v once the raw input has read v for D+1 consecutive
    // edges, counted two edges late because of the synchroniser
    task automatic model_edge(input logic x, input logic o, input logic [8:0] s);
        int n;
        logic [10:0] r;
        bit ex, eo, es;
        logic rx, ro;
        rx = m_x & ~m_x_d1;
        ro = m_o & ~m_o_d1;
        if (!m_busy) begin
            m_bx = rx;
            m_bo = ro;
            if (rx || ro) begin
                m_busy = 1'b1;
                m_selpos = m_sel;
            end
        end else begin
            m_bx = 1'b0;
            m_bo = 1'b0;
            if (!m_x && !m_o) m_busy = 1'b0;
        end
        m_multi = $countones(m_sel) >= 2;
        m_x_d1 = m_x;
        m_o_d1 = m_o;
        h.push_back({x, o, s});
        n = h.size();
        r = h[n-3];
        ex = 1; eo = 1; es = 1;
        for (int k = n - 3 - D; k < n - 3; k++) begin
            ex &= h[k][10] == r[10];
            eo &= h[k][9] == r[9];
            es &= h[k][8:0] == r[8:0];
        end
        if (ex) m_x = r[10];
        if (eo) m_o = r[9];
        if (es) m_sel = r[8:0];
        void'(h.pop_front());
    endtask

    task automatic mark();
        stp = 0; nx = 0; no_ = 0; fx = -1; fo = -1; busy_hi = 0; sx_pos = '0;
    endtask

    task automatic step(input logic x, input logic o, input logic [8:0] s);
        raw_buttonX = x;
        raw_buttonO = o;
        raw_sel = s;
        @(posedge clk);
        model_edge(x, o, s);
        #1;
        chk("buttonX", {8'b0, buttonX}, {8'b0, m_bx});
        chk("buttonO", {8'b0, buttonO}, {8'b0, m_bo});
        chk("busy", {8'b0, busy}, {8'b0, m_busy});
        chk("multi_sel", {8'b0, multi_sel}, {8'b0, m_multi});
        chk("sel_pos", sel_pos, m_selpos);
        if (buttonX === 1'b1) begin nx++; if (fx < 0) begin fx = stp; sx_pos = sel_pos; end end
        if (buttonO === 1'b1) begin no_++; if (fo < 0) fo = stp; end
        if (busy === 1'b1) busy_hi++;
        stp++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel_pos"}, sel_pos, 9'h000);
        chk({tag, "_bx"}, {8'b0, buttonX}, 9'h0);
        chk({tag, "_bo"}, {8'b0, buttonO}, 9'h0);
        chk({tag, "_multi"}, {8'b0, multi_sel}, 9'h0);
        chk({tag, "_busy"}, {8'b0, busy}, 9'h0);
    endtask

    initial begin
        logic [8:0] pool [6];
        pool = '{9'h000, 9'h010, 9'h003, 9'h100, 9'h1ff, 9'h044};
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;
        model_reset();
        // clean X press with one square selected
        repeat (10) step(0, 0, 9'h010);
        mark();
        repeat (20) step(1, 0, 9'h010);
        repeat (10) step(0, 0, 9'h010);
        chk("press_x_count", 9'(nx), 9'd1);
        chk("press_x_latency", 9'(fx), 9'd7);
        chk("press_x_sel", sx_pos, 9'h010);
        chk("press_x_no_o", 9'(no_), 9'd0);
        chk("press_x_idle", {8'b0, busy}, 9'h0);
        // O bounce of 1-cycle pulses
        mark();
        step(0, 1, 9'h010); step(0, 0, 9'h010); step(0, 1, 9'h010); step(0, 0, 9'h010);
        repeat (12) step(0, 0, 9'h010);
        chk("bounce_no_o", 9'(no_), 9'd0);
        chk("bounce_not_busy", 9'(busy_hi), 9'd0);
        // simultaneous presses
        mark();
        repeat (12) step(1, 1, 9'h010);
        chk("simul_x", 9'(fx), 9'd7);
        chk("simul_o", 9'(fo), 9'd7);
        chk("simul_busy", {8'b0, busy}, 9'h1);
        repeat (12) step(0, 0, 9'h010);
        // O pressed while X held is ignored; later clean O press strobes once
        mark();
        repeat (10) step(1, 0, 9'h010);
        repeat (10) step(1, 1, 9'h010);
        repeat (12) step(0, 0, 9'h010);
        chk("held_no_o", 9'(no_), 9'd0);
        repeat (10) step(0, 1, 9'h010);
        repeat (12) step(0, 0, 9'h010);
        chk("held_x_once", 9'(nx), 9'd1);
        chk("later_o_once", 9'(no_), 9'd1);
        // multi-square flag and stale snapshot
        repeat (10) step(0, 0, 9'h003);
        chk("multi_hi", {8'b0, multi_sel}, 9'h1);
        repeat (10) step(0, 0, 9'h100);
        chk("multi_lo", {8'b0, multi_sel}, 9'h0);
        mark();
        repeat (5) step(1, 0, 9'h100);
        repeat (10) step(1, 0, 9'h001);
        chk("stale_sel_time", 9'(fx), 9'd7);
        chk("stale_sel_val", sx_pos, 9'h100);
        repeat (12) step(0, 0, 9'h001);
        // async reset while X is mid-debounce
        repeat (10) step(0, 0, 9'h003);
        mark();
        repeat (4) step(1, 0, 9'h003);
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        mark();
        repeat (12) step(1, 0, 9'h003);
        chk("post_reset_count", 9'(nx), 9'd1);
        chk("post_reset_latency", 9'(fx), 9'd7);
        repeat (12) step(0, 0, 9'h003);
        // random traffic against the reference model
        for (int seg = 0; seg < 80; seg++) begin
            logic x, o;
            logic [8:0] s;
            int len;
            x = $urandom_range(0, 2) == 0;
            o = $urandom_range(0, 2) == 0;
            s = ($urandom_range(0, 3) == 0) ? 9'($urandom) : pool[$urandom_range(0, 5)];
            len = $urandom_range(1, 10);
            repeat (len) step(x, o, s);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
